seg7_pattern_decoder: RTL and testbench

- Receive-side counterpart of the 7-segment encoder: samples segment lines a..g, debounces them and decodes the glyph back to a 4-bit hex digit.
- Flags blank and unrecognised patterns.
- Counts accepted digit changes for on-board self-check of the counter/display path.
- Sits beside the display logic, fed by the same segment nets; its outputs are probe-friendly for the logic analyzer.

---
 rtl/seg7_pattern_decoder.sv | 177 +++++++++++++++++
 tb/tb_seg7_pattern_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: samples 7-segment lines, debounces them and decodes the glyph back to a hex digit.
// Define SEG7_DEC_SEQCHK_EN to add the o_seq_err digit-sequence checker.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 0,
    parameter int COUNT_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [6:0]         i_seg,
    input  logic               i_clr,
    output logic [3:0]         o_digit,
    output logic               o_valid,
    output logic               o_blank,
    output logic               o_invalid,
    output logic               o_locked,
    output logic [COUNT_W-1:0] o_change_cnt,
    output logic [COUNT_W-1:0] o_err_cnt
`ifdef SEG7_DEC_SEQCHK_EN
    ,
    output logic               o_seq_err
`endif
);

    // state    | meaning
    // UNLOCKED | waiting for the synchronised pattern to hold steady
    // ACCEPT   | pattern just taken; o_valid pulse visible this cycle
    // LOCKED   | input still matches the accepted pattern
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACCEPT   = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [7:0]         CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_SAT = '1;

    state_t     state, state_nxt;
    logic [6:0] sync1, sync2, s, s_prev, acc_pat;
    logic [7:0] cnt;
    logic       last_digit;
    logic       dec_hit;
    logic [3:0] dec_digit;
    logic       is_blank, is_inv;
    logic       do_accept, new_valid, err_inc;

    assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1  <= '0;
            sync2  <= '0;
            s_prev <= '0;
            cnt    <= '0;
        end else begin
            sync1  <= i_seg;
            sync2  <= sync1;
            s_prev <= s;
            if (s != s_prev)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 8'd1;
        end
    end

    always_comb begin
        dec_hit   = 1'b1;
        dec_digit = 4'h0;
        case (s)
            7'h7E:   dec_digit = 4'h0;
            7'h30:   dec_digit = 4'h1;
            7'h6D:   dec_digit = 4'h2;
            7'h79:   dec_digit = 4'h3;
            7'h33:   dec_digit = 4'h4;
            7'h5B:   dec_digit = 4'h5;
            7'h5F:   dec_digit = 4'h6;
            7'h70:   dec_digit = 4'h7;
            7'h7F:   dec_digit = 4'h8;
            7'h7B:   dec_digit = 4'h9;
            7'h77:   dec_digit = 4'hA;
            7'h1F:   dec_digit = 4'hB;
            7'h4E:   dec_digit = 4'hC;
            7'h3D:   dec_digit = 4'hD;
            7'h4F:   dec_digit = 4'hE;
            7'h47:   dec_digit = 4'hF;
            default: dec_hit   = 1'b0;
        endcase
    end

    assign is_blank = (s == 7'h00);
    assign is_inv   = !dec_hit && !is_blank;

    always_comb begin
        state_nxt = state;
        do_accept = 1'b0;
        case (state)
            UNLOCKED: begin
                if ((s == s_prev) && (cnt == CNT_MAX)) begin
                    state_nxt = ACCEPT;
                    do_accept = 1'b1;
                end
            end
            ACCEPT:  state_nxt = LOCKED;
            LOCKED: begin
                if (s != acc_pat)
                    state_nxt = UNLOCKED;
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    // A repeat of the shown digit only counts as new if a blank/invalid came in between
    assign new_valid = do_accept && dec_hit && ((dec_digit != o_digit) || !last_digit);
    assign o_locked  = (state == LOCKED);

`ifdef SEG7_DEC_SEQCHK_EN
    logic seq_have_prev, seq_bad;

    assign seq_bad = new_valid && seq_have_prev && (dec_digit != o_digit + 4'd1);
    assign err_inc = (do_accept && is_inv) || seq_bad;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            seq_have_prev <= 1'b0;
            o_seq_err     <= 1'b0;
        end else if (i_clr) begin
            seq_have_prev <= 1'b0;
            o_seq_err     <= 1'b0;
        end else if (new_valid) begin
            seq_have_prev <= 1'b1;
            if (seq_bad)
                o_seq_err <= 1'b1;
        end
    end
`else
    assign err_inc = do_accept && is_inv;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= UNLOCKED;
            acc_pat    <= '0;
            last_digit <= 1'b0;
            o_digit    <= '0;
            o_valid    <= 1'b0;
            o_blank    <= 1'b0;
            o_invalid  <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_valid <= new_valid;
            if (do_accept) begin
                acc_pat    <= s;
                last_digit <= dec_hit;
                o_blank    <= is_blank;
                o_invalid  <= is_inv;
                if (dec_hit)
                    o_digit <= dec_digit;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_change_cnt <= '0;
            o_err_cnt    <= '0;
        end else if (i_clr) begin
            o_change_cnt <= '0;
            o_err_cnt    <= '0;
        end else begin
            if (new_valid && (o_change_cnt != CNT_SAT))
                o_change_cnt <= o_change_cnt + COUNT_W'(1);
            if (err_inc && (o_err_cnt != CNT_SAT))
                o_err_cnt <= o_err_cnt + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder: active-high instance plus an active-low, 2-bit-counter instance.
module tb_seg7_pattern_decoder;

`ifdef SEG7_DEC_SEQCHK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr;
    logic [6:0]  seg, seg_al;
    logic [3:0]  digit, al_digit;
    logic        valid, blank, invalid, locked;
    logic        al_valid, al_blank, al_invalid, al_locked;
    logic [15:0] chg_cnt, err_cnt;
    logic [1:0]  al_chg_cnt, al_err_cnt;
`ifdef SEG7_DEC_SEQCHK_EN
    logic        seq_err, al_seq_err;
`endif

    seg7_pattern_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(0), .COUNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_clr(clr),
        .o_digit(digit), .o_valid(valid), .o_blank(blank), .o_invalid(invalid),
        .o_locked(locked), .o_change_cnt(chg_cnt), .o_err_cnt(err_cnt)
`ifdef SEG7_DEC_SEQCHK_EN
        , .o_seq_err(seq_err)
`endif
    );

    seg7_pattern_decoder #(.STABLE_CYCLES(4), .ACTIVE_LOW(1), .COUNT_W(2)) dut_al (
        .i_clk(clk), .i_rst(rst), .i_seg(seg_al), .i_clr(clr),
        .o_digit(al_digit), .o_valid(al_valid), .o_blank(al_blank), .o_invalid(al_invalid),
        .o_locked(al_locked), .o_change_cnt(al_chg_cnt), .o_err_cnt(al_err_cnt)
`ifdef SEG7_DEC_SEQCHK_EN
        , .o_seq_err(al_seq_err)
`endif
    );

    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int n_vec = 0;
    int n_bad = 0;
    int vcnt = 0;
    int al_vcnt = 0;
    int v0;

    always @(negedge clk) begin
        if (valid === 1'b1) vcnt++;
        if (al_valid === 1'b1) al_vcnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; seg = 7'h00; seg_al = 7'h00;
        tick(3);
        chk("rst_digit", digit, 0);
        chk("rst_valid", valid, 0);
        chk("rst_blank", blank, 0);
        chk("rst_invalid", invalid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_chg", chg_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_al_locked", al_locked, 0);
        chk("rst_al_chg", al_chg_cnt, 0);

        // first glyph: o_valid rises after edge 7
        rst = 1'b0; seg = 7'h7E; seg_al = 7'h01;
        tick(6);
        chk("first_pre_valid", valid, 0);
        chk("first_al_pre_valid", al_valid, 0);
        tick(1);
        chk("first_valid", valid, 1);
        chk("first_digit", digit, 0);
        chk("first_chg", chg_cnt, 1);
        chk("first_al_valid", al_valid, 1);
        chk("first_al_digit", al_digit, 0);
        tick(3);
        chk("first_locked", locked, 1);
        chk("first_valid_low", valid, 0);
        chk("first_vcnt", vcnt, 1);

        for (int k = 1; k <= 16; k++) begin
            seg = glyph[k % 16];
            seg_al = ~glyph[k % 16];
            tick(7);
            chk($sformatf("step%0d_valid", k), valid, 1);
            chk($sformatf("step%0d_digit", k), digit, k % 16);
            chk($sformatf("step%0d_al_digit", k), al_digit, k % 16);
            tick(1);
        end
        chk("step_chg", chg_cnt, 17);
        chk("step_vcnt", vcnt, 17);
        chk("step_al_vcnt", al_vcnt, 17);
        chk("step_al_chg_sat", al_chg_cnt, 3);
`ifdef SEG7_DEC_SEQCHK_EN
        chk("step_seq_err", seq_err, 0);
        chk("step_al_seq_err", al_seq_err, 0);
`endif

        seg = 7'h30; tick(2); seg = 7'h7E; tick(1);
        chk("glitch_unlock", locked, 0);
        tick(12);
        chk("glitch_relock", locked, 1);
        chk("glitch_vcnt", vcnt, 17);
        chk("glitch_digit", digit, 0);
        chk("glitch_chg", chg_cnt, 17);

        seg = 7'h30; tick(8);
        chk("one_digit", digit, 1);
        chk("one_chg", chg_cnt, 18);
        seg = 7'h00; tick(8);
        chk("blank_blank", blank, 1);
        chk("blank_invalid", invalid, 0);
        chk("blank_digit", digit, 1);
        seg = 7'h55; tick(8);
        chk("inv_invalid", invalid, 1);
        chk("inv_blank", blank, 0);
        chk("inv_err", err_cnt, 1);
        chk("inv_digit", digit, 1);
        chk("inv_vcnt", vcnt, 18);
        seg = 7'h30; tick(7);
        chk("redigit_valid", valid, 1);
        chk("redigit_blank", blank, 0);
        chk("redigit_invalid", invalid, 0);
        tick(1);
        chk("redigit_chg", chg_cnt, 19);
        chk("redigit_err", err_cnt, (SEQ_ON != 0) ? 2 : 1);
`ifdef SEG7_DEC_SEQCHK_EN
        chk("redigit_seq_err", seq_err, 1);
`endif

        // clear lands on the same edge as the increment
        seg = 7'h6D; tick(6); clr = 1'b1; tick(1);
        chk("clrinc_valid", valid, 1);
        chk("clrinc_digit", digit, 2);
        chk("clrinc_chg", chg_cnt, 0);
        chk("clrinc_err", err_cnt, 0);
`ifdef SEG7_DEC_SEQCHK_EN
        chk("clrinc_seq_err", seq_err, 0);
`endif
        clr = 1'b0; tick(1);

        seg = 7'h79; tick(8);
        chk("seq3_digit", digit, 3);
        chk("seq3_err", err_cnt, 0);
        seg = 7'h5B; tick(8);
        chk("seq5_digit", digit, 5);
        chk("seq5_chg", chg_cnt, 2);
        chk("seq5_err", err_cnt, (SEQ_ON != 0) ? 1 : 0);
`ifdef SEG7_DEC_SEQCHK_EN
        chk("seq5_seq_err", seq_err, 1);
`endif
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("clr_chg", chg_cnt, 0);
        chk("clr_err", err_cnt, 0);
`ifdef SEG7_DEC_SEQCHK_EN
        chk("clr_seq_err", seq_err, 0);
`endif

        seg = 7'h4F; seg_al = ~7'h4F; tick(4);
        #2 rst = 1'b1;
        #1;
        chk("arst_digit", digit, 0);
        chk("arst_locked", locked, 0);
        chk("arst_blank", blank, 0);
        chk("arst_invalid", invalid, 0);
        chk("arst_al_digit", al_digit, 0);
        chk("arst_al_chg", al_chg_cnt, 0);
        chk("arst_al_err", al_err_cnt, 0);
        chk("arst_al_blank", al_blank, 0);
        chk("arst_al_invalid", al_invalid, 0);
        tick(2);
        rst = 1'b0;
        v0 = vcnt;
        tick(6);
        chk("arst_no_early_valid", vcnt, v0);
        chk("arst_pre_valid", valid, 0);
        tick(1);
        chk("arst_valid", valid, 1);
        chk("arst_digit_e", digit, 4'hE);
        chk("arst_al_valid", al_valid, 1);
        chk("arst_al_digit_e", al_digit, 4'hE);
        tick(1);
        chk("arst_chg", chg_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
